demux_scan_sequencer: RTL and testbench

- Upstream controller for the 3-to-8 demultiplexer. Drives its `sel` and `in` inputs.
- Scans the enabled channels in ascending index order. Each channel is held for a programmable dwell time, and the serial input `data_in` is routed to it during that time.
- A start/busy/done handshake lets a host trigger a single scan pass, or continuous scanning when the optional feature is compiled in.

---
 rtl/demux_seq_pkg.sv | 35 +++
 rtl/demux_scan_sequencer_next_chan_finder.sv | 43 ++++
 rtl/demux_scan_sequencer.sv | 157 +++++++++++++++
 tb/tb_demux_scan_sequencer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/demux_seq_pkg.sv
// -----------------------------------------------------------------------------
// demux_seq_pkg
// Shared definitions for the demultiplexer scan sequencer:
//   - state_t     : sequencer FSM states (IDLE, SCAN, DONE)
//   - SEL_W_DEF   : default select width (the downstream demux is 3-to-8)
//   - N_CH_DEF    : default channel count derived from SEL_W_DEF
//   - MAX_CH      : widest mask the lowest_set helper accepts
//   - lowest_set  : index of the lowest set bit of a mask (0 when mask is 0)
// Optional build macro used by the top: DEMUX_SEQ_CONTINUOUS_EN.
// -----------------------------------------------------------------------------
package demux_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SEL_W_DEF = 3;
    localparam int N_CH_DEF  = 2 ** SEL_W_DEF;
    localparam int MAX_CH    = 256;

    // Descending loop so the lowest set bit is the last one written.
    function automatic logic [7:0] lowest_set(input logic [MAX_CH-1:0] mask);
        logic [7:0] idx;
        idx = '0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = 8'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/demux_scan_sequencer_next_chan_finder.sv
// -----------------------------------------------------------------------------
// next_chan_finder
// Combinational channel lookup over an enable mask.
//   mask        in  N_CH   channel enable mask
//   cur         in  SEL_W  currently selected channel
//   next_idx    out SEL_W  lowest set index strictly above cur
//   next_found  out 1      a set index above cur exists
//   first_idx   out SEL_W  lowest set index of the whole mask
//   first_found out 1      mask is non-zero
// The "first" outputs are the search-from-below-zero case, used both for the
// initial channel of a pass and for wrapping back in continuous scanning.
// -----------------------------------------------------------------------------
module next_chan_finder
    import demux_seq_pkg::*;
#(
    parameter int SEL_W = SEL_W_DEF
) (
    input  logic [(2**SEL_W)-1:0] mask,
    input  logic [SEL_W-1:0]      cur,
    output logic [SEL_W-1:0]      next_idx,
    output logic                  next_found,
    output logic [SEL_W-1:0]      first_idx,
    output logic                  first_found
);

    localparam int N_CH = 2 ** SEL_W;

    always_comb begin
        next_idx   = '0;
        next_found = 1'b0;
        // Descending so the lowest qualifying index wins.
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) begin
                next_idx   = SEL_W'(i);
                next_found = 1'b1;
            end
        end
    end

    assign first_idx   = SEL_W'(lowest_set(MAX_CH'(mask)));
    assign first_found = |mask;

endmodule

// File: rtl/demux_scan_sequencer.sv
// -----------------------------------------------------------------------------
// demux_scan_sequencer
// Drives the sel/in inputs of a 3-to-8 demultiplexer. Visits the enabled
// channels in ascending order, holding each for dwell+1 cycles while routing
// data_in to it. A host starts a single pass with start; abort ends a scan
// early without a done pulse.
//
// Ports:
//   clk        in   1        rising-edge clock
//   rst_n      in   1        synchronous active-low reset
//   start      in   1        start request, sampled only in IDLE
//   abort      in   1        ends SCAN on the next edge, no done pulse
//   chan_mask  in   N_CH     channel enables, latched at start
//   dwell      in   DWELL_W  cycles per channel minus one, latched at start
//   data_in    in   1        serial data to distribute
//   cont       in   1        (DEMUX_SEQ_CONTINUOUS_EN only) wrap to first
//                            channel instead of finishing the pass
//   sel        out  SEL_W    demux channel select
//   demux_in   out  1        data_in gated by SCAN (combinational)
//   busy       out  1        high while scanning
//   done       out  1        one-cycle pulse at the end of a pass
//   chan_first out  1        first cycle of each channel's dwell
//
// Build macro: DEMUX_SEQ_CONTINUOUS_EN adds the cont port and wrap-around.
//
// Handshake: start is honoured only in IDLE (level or pulse); while busy or
// in DONE it is ignored, not queued. busy rises the cycle after the accepting
// edge; done pulses for one cycle after the last channel, then IDLE follows.
// -----------------------------------------------------------------------------
module demux_scan_sequencer
    import demux_seq_pkg::*;
#(
    parameter int SEL_W   = SEL_W_DEF,
    parameter int DWELL_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [(2**SEL_W)-1:0] chan_mask,
    input  logic [DWELL_W-1:0]    dwell,
    input  logic                  data_in,
`ifdef DEMUX_SEQ_CONTINUOUS_EN
    input  logic                  cont,
`endif
    output logic [SEL_W-1:0]      sel,
    output logic                  demux_in,
    output logic                  busy,
    output logic                  done,
    output logic                  chan_first
);

    localparam int N_CH = 2 ** SEL_W;

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [DWELL_W-1:0]  cnt_q, cnt_d;
    logic [N_CH-1:0]     mask_q, mask_d;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;

    logic [N_CH-1:0]     find_mask;
    logic [SEL_W-1:0]    next_idx;
    logic                next_found;
    logic [SEL_W-1:0]    first_idx;
    logic                first_found;
    logic                wrap_en;

`ifdef DEMUX_SEQ_CONTINUOUS_EN
    assign wrap_en = cont;
`else
    assign wrap_en = 1'b0;
`endif

    // In IDLE the lookup must see the live mask (first channel of a new
    // pass); otherwise it works on the latched copy.
    assign find_mask = (state_q == IDLE) ? chan_mask : mask_q;

    next_chan_finder #(
        .SEL_W (SEL_W)
    ) u_finder (
        .mask        (find_mask),
        .cur         (sel_q),
        .next_idx    (next_idx),
        .next_found  (next_found),
        .first_idx   (first_idx),
        .first_found (first_found)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            mask_q  <= '0;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            dwell_q <= dwell_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        dwell_d = dwell_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mask_d  = chan_mask;
                    dwell_d = dwell;
                    if (first_found) begin
                        sel_d   = first_idx;
                        cnt_d   = '0;
                        state_d = SCAN;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            SCAN: begin
                // abort outranks every channel-advance decision.
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_q < dwell_q) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (next_found) begin
                    sel_d = next_idx;
                    cnt_d = '0;
                end else if (wrap_en) begin
                    sel_d = first_idx;
                    cnt_d = '0;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sel        = sel_q;
    assign busy       = (state_q == SCAN);
    assign done       = (state_q == DONE);
    // The counter restarts at zero on every channel entry.
    assign chan_first = (state_q == SCAN) && (cnt_q == '0);
    assign demux_in   = data_in & (state_q == SCAN);

endmodule

// File: tb/tb_demux_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_demux_scan_sequencer
// Drives directed passes and a randomized stream into demux_scan_sequencer and
// compares every cycle against a schedule model: on an accepted start the
// model lays out the whole pass (one entry per cycle) in a queue.
// -----------------------------------------------------------------------------
module tb_demux_scan_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] chan_mask;
  logic [3:0] dwell;
  logic       data_in;
`ifdef DEMUX_SEQ_CONTINUOUS_EN
  logic       cont;
`endif
  logic [2:0] sel;
  logic       demux_in;
  logic       busy;
  logic       done;
  logic       chan_first;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Expected-output entries: {busy, done, chan_first, sel[2:0]}
  logic [5:0] exp_q[$];
  logic [5:0] exp_cur;
  bit         model_valid = 0;

  demux_scan_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .chan_mask  (chan_mask),
    .dwell      (dwell),
    .data_in    (data_in),
`ifdef DEMUX_SEQ_CONTINUOUS_EN
    .cont       (cont),
`endif
    .sel        (sel),
    .demux_in   (demux_in),
    .busy       (busy),
    .done       (done),
    .chan_first (chan_first)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- random serial data ----------------
  always @(posedge clk) begin
    #2 data_in = 1'($urandom);
  end

  // ---------------- schedule model ----------------
  always @(posedge clk) begin
    logic [2:0] last;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      exp_cur = 6'b000_000;
    end else if (exp_cur[5] && abort) begin
      exp_q.delete();
      exp_cur = {3'b000, exp_cur[2:0]};
    end else if (!exp_cur[5] && !exp_cur[4] && start) begin
      last = exp_cur[2:0];
      for (int ch = 0; ch < 8; ch++) begin
        if (chan_mask[ch]) begin
          for (int j = 0; j <= int'(dwell); j++) begin
            exp_q.push_back({1'b1, 1'b0, (j == 0), 3'(ch)});
          end
          last = 3'(ch);
        end
      end
      exp_q.push_back({3'b010, last});
      exp_cur = exp_q.pop_front();
    end else if (exp_q.size() != 0) begin
      exp_cur = exp_q.pop_front();
    end else begin
      exp_cur = {3'b000, exp_cur[2:0]};
    end
    model_valid = 1;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (model_valid) begin
      check("busy", 32'(busy), 32'(exp_cur[5]));
      check("done", 32'(done), 32'(exp_cur[4]));
      check("chan_first", 32'(chan_first), 32'(exp_cur[3]));
      check("sel", 32'(sel), 32'(exp_cur[2:0]));
      check("demux_in", 32'(demux_in), 32'(data_in & exp_cur[5]));
    end
  end

  // ---------------- driver tasks ----------------
  // One pass: measures done cycle relative to the start edge (start edge T,
  // first SCAN cycle is T+1), busy cycles and chan_first pulses.
  task automatic run_pass(input logic [7:0] m, input logic [3:0] d, input bit mid_start,
                          input int exp_done, input int exp_busy, input int exp_first,
                          input string name);
    int t;
    int done_at;
    int nb;
    int nf;
    @(posedge clk);
    #2 chan_mask = m; dwell = d; start = 1'b1;
    t = cyc + 1;
    @(posedge clk);
    // Scrambling the inputs mid-pass must not disturb the latched copies.
    #2 start = 1'b0; chan_mask = 8'($urandom); dwell = 4'($urandom);
    done_at = -1; nb = 0; nf = 0;
    for (int k = 0; k < 300 && done_at < 0; k++) begin
      @(negedge clk);
      if (busy) nb++;
      if (chan_first) nf++;
      if (done) done_at = cyc - t + 1;
      if (mid_start && k == 2) start = 1'b1;
      if (mid_start && k == 4) start = 1'b0;
    end
    start = 1'b0;
    check({name, "_done_cycle"}, 32'(done_at), 32'(exp_done));
    check({name, "_busy_cycles"}, 32'(nb), 32'(exp_busy));
    check({name, "_first_pulses"}, 32'(nf), 32'(exp_first));
  endtask

  task automatic count_dones(input int n, input string name);
    int nd;
    nd = 0;
    repeat (n) begin
      @(negedge clk);
      if (done) nd++;
    end
    check(name, 32'(nd), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; chan_mask = '0; dwell = '0; data_in = 1'b0;
`ifdef DEMUX_SEQ_CONTINUOUS_EN
    cont = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_sel", 32'(sel), 32'd0);
    check("reset_chan_first", 32'(chan_first), 32'd0);

    // Reset held for three cycles in the middle of a scan.
    @(posedge clk);
    #2 chan_mask = 8'hFF; dwell = 4'd3; start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_sel", 32'(sel), 32'd0);
    check("midreset_done", 32'(done), 32'd0);
    count_dones(20, "midreset_no_done");

    // Directed passes.
    run_pass(8'hFF, 4'd0, 1'b0, 9, 8, 8, "full_scan");
    run_pass(8'b1010_0100, 4'd2, 1'b0, 10, 9, 3, "sparse");
    run_pass(8'h00, 4'd5, 1'b0, 1, 0, 0, "zero_mask");
    run_pass(8'h0F, 4'd1, 1'b1, 9, 8, 4, "start_while_busy");
    run_pass(8'h80, 4'd15, 1'b0, 17, 16, 1, "max_dwell");
    run_pass(8'h01, 4'd0, 1'b0, 2, 1, 1, "single_ch0");

    // Abort in cycle T+4 (mask FF, dwell 1 -> channel 1 is active).
    @(posedge clk);
    #2 chan_mask = 8'hFF; dwell = 4'd1; start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 abort = 1'b1;
    @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'd1);
    check("abort_sel_before", 32'(sel), 32'd1);
    @(posedge clk);
    #2 abort = 1'b0;
    @(negedge clk);
    check("abort_busy_after", 32'(busy), 32'd0);
    check("abort_sel_held", 32'(sel), 32'd1);
    count_dones(20, "abort_no_done");

    // Abort while idle does nothing; the next start still runs a full pass.
    @(posedge clk);
    #2 abort = 1'b1;
    @(posedge clk);
    #2 abort = 1'b0;
    run_pass(8'b0001_0001, 4'd0, 1'b0, 3, 2, 2, "after_idle_abort");

    // Randomized stream; the per-cycle compare carries the checking.
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk);
      #2;
      start = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 60) == 0);
      chan_mask = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      dwell = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
      rst_n = ($urandom_range(0, 500) != 0);
    end
    @(posedge clk);
    #2 start = 1'b0; abort = 1'b0; rst_n = 1'b1;
    repeat (300) @(posedge clk);
    @(negedge clk);
    check("final_idle_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
